game_tick_scheduler: RTL and testbench
======================================

# game_tick_scheduler

Central timing controller for the Whack-a-Mole game. It owns the single clock-enable prescaler and sequences every game rate from it: the display scan strobe, the round-second countdown and the difficulty-dependent mole-step strobe. It replaces free-running toggled slow clocks with one-cycle enable pulses in the `clk` domain. It sits between the board clock and the game FSM, the mole LFSR and the 7-segment driver.

## Interface
- `BASE_DIV`, 100_000: `clk` cycles per base tick (1 ms at 100 MHz). Must be ≥ 2.
- `TICKS_PER_SEC`, 1000: base ticks per game second. Must be a multiple of 4 and ≤ 1023.
- `ROUND_SECONDS`, 60: round length. Range 1..127.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse. Starts a round from IDLE or DONE.
- `pause` in 1: level. Freezes round timing while high.
- `level` in 2: difficulty, 0 = slowest.
- `scan_tick` out 1: one-cycle pulse every base tick, in every state.
- `mole_tick` out 1: one-cycle pulse at the end of each mole period, RUN only.
- `sec_tick` out 1: one-cycle pulse per elapsed game second, RUN only.
- `seconds_left` out 7: remaining round seconds.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset enters IDLE.
- Reset values: all ticks 0, `seconds_left` = 0, `running` = 0, `done` = 0, all counters 0.
- Prescaler counts 0..BASE_DIV-1 and wraps. Base tick = (count == BASE_DIV-1). It never stops; `scan_tick` follows it in every state.
- IDLE/DONE + `start`:
  - go to RUN.
  - prescaler, ms counter and mole counter cleared.
  - `seconds_left` ← ROUND_SECONDS.
  - latch `level`.
- Mole period in base ticks is TICKS_PER_SEC·(4−L)/4. With L the latched level, this gives 100%/75%/50%/25% of a second for L = 0..3.
- RUN:
  - each base tick increments the ms counter (0..TICKS_PER_SEC-1) and the mole counter.
  - ms counter wrap → `sec_tick` and `seconds_left` decrement.
  - mole counter reaching period−1 → `mole_tick`, mole counter cleared, `level` re-latched. Level changes therefore take effect only at period boundaries.
- RUN + `pause` = 1 → PAUSED.
  - ms, mole and seconds counters hold.
  - `pause` = 0 → RUN, resuming from the held values.
- Final second: the `sec_tick` that takes `seconds_left` 1→0 is emitted, and the state moves to DONE on the same edge. A `mole_tick` coinciding with that base tick is also emitted. No ticks other than `scan_tick` in DONE.
- `start` while in RUN or PAUSED: ignored.
- `start` and `pause` in the same cycle in IDLE/DONE: `start` wins and the state goes to RUN. `pause` is evaluated from the next cycle.
- `reset` mid-round: immediate return to reset values. No tick is emitted.

## Timing
- `start` sampled at edge T:
  - `running` = 1 and `seconds_left` = ROUND_SECONDS from T+1.
  - prescaler = 0 at T+1.
- All outputs are registered.
- A tick pulse is high for exactly the one cycle following the edge at which its terminal condition is registered.
- Cycles from `start` (edge T):
  - first `scan_tick` in cycle T+BASE_DIV.
  - first `sec_tick` in cycle T+TICKS_PER_SEC·BASE_DIV.
  - first `mole_tick` in cycle T+period·BASE_DIV.
- `done` rises in the same cycle as the final `sec_tick`.
- Widths:
  - prescaler: $clog2(BASE_DIV).
  - ms and mole counters: 10 bits.
  - period computed as (TICKS_PER_SEC/4)·(4−L) in 10 bits; no overflow within the parameter ranges.

## Structure
- `game_timing_pkg`: state enum, `level_t` (2 bits), counter width localparams, `mole_period(level)` function.
- Sub-module `tick_prescaler`: BASE_DIV counter with sync clear input and one-cycle tick output. It is reusable by other blocks that need enables.
- Top FSM plus ms, mole and seconds counters live in `game_tick_scheduler`.

## Test plan
Bench parameters: BASE_DIV = 4, TICKS_PER_SEC = 8, ROUND_SECONDS = 3.
1. Reset, then idle for 40 cycles → `scan_tick` every 4 cycles; `running` = 0; no `sec_tick`/`mole_tick`; `seconds_left` = 0.
2. `start` at T with `level` = 0 →
   - `seconds_left` = 3 at T+1.
   - `sec_tick` at T+32, T+64, T+96.
   - `mole_tick` at T+32, T+64, T+96.
   - `done` = 1 at T+96; `seconds_left` = 0.
3. `level` = 3 at `start` → `mole_tick` every 8 cycles (T+8, T+16, …). Changing to `level` = 1 mid-period → old period finishes, then `mole_tick` every 24 cycles.
4. `pause` high for 50 cycles at T+20 →
   - no `sec_tick`/`mole_tick` during the pause.
   - `scan_tick` continues.
   - first `sec_tick` lands 50 ± 3 cycles later than unpaused (pause resolution is one base tick).
5. `start` during RUN → ignored, `seconds_left` unchanged. `start` and `pause` together in DONE → RUN, `seconds_left` = 3, then PAUSED on the next cycle.
6. `reset` asserted at T+40 mid-round → all outputs 0 immediately and state IDLE. `start` afterwards restarts cleanly per scenario 2.

Source files
------------

// File: rtl/game_timing_pkg.sv
// Shared state/level types, counter widths and the mole period helper for the game timing slice.
package game_timing_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_t;

  typedef logic [1:0] level_t;

  localparam int unsigned CntW = 10;
  localparam int unsigned SecW = 7;

  // Level 0..3 maps to 4/4..1/4 of a game second, in base ticks.
  function automatic logic [CntW-1:0] mole_period(input level_t lvl,
                                                  input int unsigned ticks_per_sec);
    int unsigned p;
    p = (ticks_per_sec / 4) * (4 - 32'(lvl));
    return p[CntW-1:0];
  endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Control and tick bundle between the game logic and the tick scheduler.
interface game_tick_scheduler_if;
  import game_timing_pkg::*;

  logic            start;
  logic            pause;
  level_t          level;
  logic            scan_tick;
  logic            mole_tick;
  logic            sec_tick;
  logic [SecW-1:0] seconds_left;
  logic            running;
  logic            done;

  modport master (
    output start, pause, level,
    input  scan_tick, mole_tick, sec_tick, seconds_left, running, done
  );

  modport slave (
    input  start, pause, level,
    output scan_tick, mole_tick, sec_tick, seconds_left, running, done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running BASE_DIV divider producing a registered one-cycle enable and its one-edge-early
// form, so dependent counters can register their own strobes in the same cycle as the tick.
module tick_prescaler #(
  parameter int unsigned BASE_DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_next,
  output logic tick
);

  localparam int unsigned PreW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [PreW-1:0] Last = PreW'(BASE_DIV - 1);

  logic [PreW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || (count_q == Last)) begin
      count_d = '0;
    end
  end

  assign tick_next = (count_d == Last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tick    <= 1'b0;
    end else begin
      count_q <= count_d;
      tick    <= tick_next;
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Round FSM with ms, mole and seconds counters, all stepped by the shared base-tick enable.
module game_tick_scheduler
  import game_timing_pkg::*;
#(
  parameter int unsigned BASE_DIV      = 100_000,
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned ROUND_SECONDS = 60
) (
  input logic                  clk,
  input logic                  reset,
  game_tick_scheduler_if.slave bus
);

  state_t          state_q, state_d;
  logic [CntW-1:0] ms_q, ms_d;
  logic [CntW-1:0] mole_q, mole_d;
  logic [SecW-1:0] secs_q, secs_d;
  level_t          level_q, level_d;
  logic            sec_tick_q, sec_tick_d;
  logic            mole_tick_q, mole_tick_d;
  logic            running_q, done_q;
  logic            presc_clear, pre_tick, scan_tick;
  logic [CntW-1:0] period;

  tick_prescaler #(
    .BASE_DIV(BASE_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (presc_clear),
    .tick_next(pre_tick),
    .tick     (scan_tick)
  );

  assign period = mole_period(level_q, TICKS_PER_SEC);

  always_comb begin
    state_d     = state_q;
    ms_d        = ms_q;
    mole_d      = mole_q;
    secs_d      = secs_q;
    level_d     = level_q;
    sec_tick_d  = 1'b0;
    mole_tick_d = 1'b0;
    presc_clear = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d     = StRun;
          presc_clear = 1'b1;
          ms_d        = '0;
          mole_d      = '0;
          secs_d      = SecW'(ROUND_SECONDS);
          level_d     = bus.level;
        end
      end
      StRun: begin
        // Pause wins over a coinciding base tick; that tick is simply not counted.
        if (bus.pause) begin
          state_d = StPaused;
        end else if (pre_tick) begin
          if (ms_q == CntW'(TICKS_PER_SEC - 1)) begin
            ms_d       = '0;
            sec_tick_d = 1'b1;
            secs_d     = secs_q - 1'b1;
            if (secs_q == SecW'(1)) begin
              state_d = StDone;
            end
          end else begin
            ms_d = ms_q + 1'b1;
          end
          if (mole_q == period - 1'b1) begin
            mole_d      = '0;
            mole_tick_d = 1'b1;
            level_d     = bus.level;
          end else begin
            mole_d = mole_q + 1'b1;
          end
        end
      end
      StPaused: begin
        if (!bus.pause) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ms_q        <= '0;
      mole_q      <= '0;
      secs_q      <= '0;
      level_q     <= '0;
      sec_tick_q  <= 1'b0;
      mole_tick_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_q        <= ms_d;
      mole_q      <= mole_d;
      secs_q      <= secs_d;
      level_q     <= level_d;
      sec_tick_q  <= sec_tick_d;
      mole_tick_q <= mole_tick_d;
      running_q   <= (state_d == StRun);
      done_q      <= (state_d == StDone);
    end
  end

  assign bus.scan_tick    = scan_tick;
  assign bus.mole_tick    = mole_tick_q;
  assign bus.sec_tick     = sec_tick_q;
  assign bus.seconds_left = secs_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler with BASE_DIV=4, TICKS_PER_SEC=8, ROUND_SECONDS=3.
module tb_game_tick_scheduler;
  import game_timing_pkg::*;

  localparam int unsigned BD  = 4;
  localparam int unsigned TPS = 8;
  localparam int unsigned RS  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  // Cycle stamps of observed ticks and of the ticks expected by the scoreboard.
  int obs_sec[$];
  int obs_mole[$];
  int obs_scan[$];
  int exp_sec[$];
  int exp_mole[$];

  game_tick_scheduler_if bus ();

  game_tick_scheduler #(
    .BASE_DIV     (BD),
    .TICKS_PER_SEC(TPS),
    .ROUND_SECONDS(RS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.sec_tick)  obs_sec.push_back(cyc);
      if (bus.mole_tick) obs_mole.push_back(cyc);
      if (bus.scan_tick) obs_scan.push_back(cyc);
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Returns T, the index of the edge that samples start; cycle T+k is stamped T+k.
  task automatic start_round(input level_t lvl, output int t);
    @(negedge clk);
    bus.start = 1'b1;
    bus.level = lvl;
    @(negedge clk);
    bus.start = 1'b0;
    t = cyc - 1;
  endtask

  task automatic test_reset();
    int c0, n, prev;
    @(negedge clk);
    checks++;
    if ({bus.scan_tick, bus.sec_tick, bus.mole_tick, bus.running, bus.done} !== 5'b0 ||
        bus.seconds_left !== 7'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ticks/run/done=%b secs=%0d want 0",
               {bus.scan_tick, bus.sec_tick, bus.mole_tick, bus.running, bus.done},
               bus.seconds_left);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    wait_until(c0 + 40);
    n = 0;
    prev = -1;
    foreach (obs_scan[i]) begin
      if (obs_scan[i] > c0 && obs_scan[i] <= c0 + 40) begin
        if (prev >= 0) begin
          checks++;
          if (obs_scan[i] - prev !== 4) begin
            failures++;
            $display("FAIL idle_scan_spacing: got %0d want 4", obs_scan[i] - prev);
          end
        end
        prev = obs_scan[i];
        n++;
      end
    end
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL idle_scan_count: got %0d want 10", n);
    end
    checks++;
    if (obs_sec.size() + obs_mole.size() !== 0) begin
      failures++;
      $display("FAIL idle_no_round_ticks: got %0d want 0", obs_sec.size() + obs_mole.size());
    end
    checks++;
    if (bus.running !== 1'b0 || bus.seconds_left !== 7'd0) begin
      failures++;
      $display("FAIL idle_state: got run=%b secs=%0d want run=0 secs=0",
               bus.running, bus.seconds_left);
    end
  endtask

  task automatic test_basic_round(input string tag);
    int t, e, o;
    obs_sec.delete();
    obs_mole.delete();
    start_round(2'd0, t);
    checks++;
    if (bus.seconds_left !== 7'd3 || bus.running !== 1'b1) begin
      failures++;
      $display("FAIL %s_start: got secs=%0d run=%b want secs=3 run=1",
               tag, bus.seconds_left, bus.running);
    end
    for (int k = 1; k <= 3; k++) begin
      exp_sec.push_back(t + 32 * k);
      exp_mole.push_back(t + 32 * k);
    end
    wait_until(t + 95);
    checks++;
    if (bus.done !== 1'b0 || bus.seconds_left !== 7'd1) begin
      failures++;
      $display("FAIL %s_before_end: got done=%b secs=%0d want done=0 secs=1",
               tag, bus.done, bus.seconds_left);
    end
    wait_until(t + 96);
    checks++;
    if (bus.done !== 1'b1 || bus.seconds_left !== 7'd0 || bus.running !== 1'b0) begin
      failures++;
      $display("FAIL %s_done: got done=%b secs=%0d run=%b want done=1 secs=0 run=0",
               tag, bus.done, bus.seconds_left, bus.running);
    end
    wait_until(t + 140);
    while (exp_sec.size() > 0) begin
      e = exp_sec.pop_front();
      o = (obs_sec.size() > 0) ? obs_sec.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_sec_tick: got cycle T+%0d want T+%0d", tag, o - t, e - t);
      end
    end
    while (exp_mole.size() > 0) begin
      e = exp_mole.pop_front();
      o = (obs_mole.size() > 0) ? obs_mole.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_mole_tick: got cycle T+%0d want T+%0d", tag, o - t, e - t);
      end
    end
    checks++;
    if (obs_sec.size() + obs_mole.size() !== 0) begin
      failures++;
      $display("FAIL %s_extra_ticks: got %0d want 0", tag, obs_sec.size() + obs_mole.size());
    end
  endtask

  task automatic test_level_change();
    int t, e, o;
    obs_sec.delete();
    obs_mole.delete();
    start_round(2'd3, t);
    // Level 3 period is 2 base ticks; level 1 (6 base ticks) applies after the T+16 boundary.
    exp_mole = '{t + 8, t + 16, t + 40, t + 64, t + 88};
    exp_sec  = '{t + 32, t + 64, t + 96};
    wait_until(t + 12);
    bus.level = 2'd1;
    wait_until(t + 140);
    bus.level = 2'd0;
    while (exp_mole.size() > 0) begin
      e = exp_mole.pop_front();
      o = (obs_mole.size() > 0) ? obs_mole.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL level_mole_tick: got cycle T+%0d want T+%0d", o - t, e - t);
      end
    end
    while (exp_sec.size() > 0) begin
      e = exp_sec.pop_front();
      o = (obs_sec.size() > 0) ? obs_sec.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL level_sec_tick: got cycle T+%0d want T+%0d", o - t, e - t);
      end
    end
    checks++;
    if (obs_sec.size() + obs_mole.size() !== 0) begin
      failures++;
      $display("FAIL level_extra_ticks: got %0d want 0", obs_sec.size() + obs_mole.size());
    end
  endtask

  task automatic test_pause();
    int t, n_scan, n_frozen;
    obs_sec.delete();
    obs_mole.delete();
    start_round(2'd0, t);
    wait_until(t + 20);
    bus.pause = 1'b1;
    wait_until(t + 30);
    checks++;
    if (bus.running !== 1'b0 || bus.seconds_left !== 7'd3) begin
      failures++;
      $display("FAIL pause_hold: got run=%b secs=%0d want run=0 secs=3",
               bus.running, bus.seconds_left);
    end
    wait_until(t + 70);
    bus.pause = 1'b0;
    wait_until(t + 180);
    n_scan = 0;
    n_frozen = 0;
    foreach (obs_scan[i]) if (obs_scan[i] > t + 20 && obs_scan[i] <= t + 70) n_scan++;
    foreach (obs_sec[i]) if (obs_sec[i] > t + 20 && obs_sec[i] <= t + 70) n_frozen++;
    foreach (obs_mole[i]) if (obs_mole[i] > t + 20 && obs_mole[i] <= t + 70) n_frozen++;
    checks++;
    if (n_scan < 12) begin
      failures++;
      $display("FAIL pause_scan_continues: got %0d want >=12", n_scan);
    end
    checks++;
    if (n_frozen !== 0) begin
      failures++;
      $display("FAIL pause_no_round_ticks: got %0d want 0", n_frozen);
    end
    checks++;
    if (obs_sec.size() !== 3 || obs_mole.size() !== 3) begin
      failures++;
      $display("FAIL pause_tick_count: got sec=%0d mole=%0d want 3 and 3",
               obs_sec.size(), obs_mole.size());
    end else begin
      checks++;
      if (obs_sec[0] < t + 79 || obs_sec[0] > t + 85) begin
        failures++;
        $display("FAIL pause_first_sec: got T+%0d want T+79..T+85", obs_sec[0] - t);
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (obs_sec[i] - obs_sec[i-1] !== 32 || obs_mole[i] - obs_mole[i-1] !== 32) begin
          failures++;
          $display("FAIL pause_spacing: got sec=%0d mole=%0d want 32",
                   obs_sec[i] - obs_sec[i-1], obs_mole[i] - obs_mole[i-1]);
        end
      end
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL pause_round_done: got %b want 1", bus.done);
    end
  endtask

  task automatic test_start_rules();
    int t, e, o;
    obs_sec.delete();
    obs_mole.delete();
    start_round(2'd0, t);
    exp_sec = '{t + 32, t + 64, t + 96};
    wait_until(t + 40);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.seconds_left !== 7'd2 || bus.running !== 1'b1) begin
      failures++;
      $display("FAIL start_in_run: got secs=%0d run=%b want secs=2 run=1",
               bus.seconds_left, bus.running);
    end
    wait_until(t + 100);
    while (exp_sec.size() > 0) begin
      e = exp_sec.pop_front();
      o = (obs_sec.size() > 0) ? obs_sec.pop_front() : -1;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL start_ignored_sec: got cycle T+%0d want T+%0d", o - t, e - t);
      end
    end
    bus.start = 1'b1;
    bus.pause = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.running !== 1'b1 || bus.done !== 1'b0 || bus.seconds_left !== 7'd3) begin
      failures++;
      $display("FAIL start_pause_done: got run=%b done=%b secs=%0d want run=1 done=0 secs=3",
               bus.running, bus.done, bus.seconds_left);
    end
    @(negedge clk);
    checks++;
    if (bus.running !== 1'b0 || bus.done !== 1'b0 || bus.seconds_left !== 7'd3) begin
      failures++;
      $display("FAIL start_pause_then_paused: got run=%b done=%b secs=%0d want 0 0 3",
               bus.running, bus.done, bus.seconds_left);
    end
    bus.pause = 1'b0;
    wait_until(cyc + 120);
  endtask

  task automatic test_reset_mid_round();
    int t, n;
    obs_sec.delete();
    obs_mole.delete();
    start_round(2'd0, t);
    wait_until(t + 40);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.scan_tick, bus.sec_tick, bus.mole_tick, bus.running, bus.done} !== 5'b0 ||
        bus.seconds_left !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got ticks/run/done=%b secs=%0d want 0",
               {bus.scan_tick, bus.sec_tick, bus.mole_tick, bus.running, bus.done},
               bus.seconds_left);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n = 0;
    foreach (obs_sec[i]) if (obs_sec[i] > t + 32) n++;
    foreach (obs_mole[i]) if (obs_mole[i] > t + 32) n++;
    checks++;
    if (n !== 0 || bus.running !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle: got ticks=%0d run=%b want 0 0", n, bus.running);
    end
    test_basic_round("restart");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.level = 2'd0;
    test_reset();
    test_basic_round("basic");
    test_level_change();
    test_pause();
    test_start_rules();
    test_reset_mid_round();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
